alu_ctrl_unit: RTL and testbench

//  ALU control decoder for the single-cycle MIPS datapath. Maps the 2-bit alu_op

---
 rtl/alu_ctrl_unit.sv | 107 ++++++++++
 tb/tb_alu_ctrl_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_unit.sv
// ALU control decoder: maps alu_op plus the R-type funct field to the ALU select, with a sticky illegal-funct side-band.
// Latency: the decode is combinational (zero cycles); the illegal_seen/illegal_cnt side-band updates on the next rising clk.
// Backpressure: none; every cycle is a valid decode, and err_clr clears the side-band synchronously.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset (side-band only)
//   alu_op[1:0]   00 load/store, 01 branch, 10 R-type, 11 addi
//   func[5:0]     instruction funct field, only looked at when alu_op == 10
//   err_clr       synchronous clear of illegal_seen / illegal_cnt
//   alu_ctrl[3:0] ALU operation select (combinational)
//   illegal_func  alu_op == 10 with an undefined funct (combinational)
//   illegal_seen  sticky flag: an illegal funct was sampled since reset or clear
//   illegal_cnt   saturating count of cycles sampled with illegal_func == 1
module alu_ctrl_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic             err_clr,
  output logic [3:0]       alu_ctrl,
  output logic             illegal_func,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_INV  = 4'b1111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             illegal_seen_q, illegal_seen_d;
  logic [CNT_W-1:0] illegal_cnt_q,  illegal_cnt_d;

  // The outer case uses case-equality semantics, so an X/Z alu_op matches no
  // item and falls to the INVALID/not-illegal defaults. func is only examined
  // inside the R-type branch, so it can never poison the other decodes.
  always_comb begin
    alu_ctrl     = OP_INV;
    illegal_func = 1'b0;
    case (alu_op)
      2'b00: alu_ctrl = OP_ADD;
      2'b01: alu_ctrl = OP_SUB;
      2'b11: alu_ctrl = OP_ADD;
      2'b10: begin
        case (func)
          6'b100000: alu_ctrl = OP_ADD;   // add
          6'b100001: alu_ctrl = OP_ADD;   // addu
          6'b100010: alu_ctrl = OP_SUB;   // sub
          6'b100011: alu_ctrl = OP_SUB;   // subu
          6'b100100: alu_ctrl = OP_AND;
          6'b100101: alu_ctrl = OP_OR;
          6'b100110: alu_ctrl = OP_XOR;
          6'b100111: alu_ctrl = OP_NOR;
          6'b101010: alu_ctrl = OP_SLT;
          6'b101011: alu_ctrl = OP_SLTU;
          default: begin
            alu_ctrl     = OP_INV;
            illegal_func = 1'b1;
          end
        endcase
      end
      default: begin
        alu_ctrl     = OP_INV;
        illegal_func = 1'b0;
      end
    endcase
  end

  // Clear takes priority over an event seen in the same cycle.
  always_comb begin
    illegal_seen_d = illegal_seen_q;
    illegal_cnt_d  = illegal_cnt_q;
    if (err_clr) begin
      illegal_seen_d = 1'b0;
      illegal_cnt_d  = '0;
    end else if (illegal_func) begin
      illegal_seen_d = 1'b1;
      if (illegal_cnt_q != CNT_MAX) begin
        illegal_cnt_d = illegal_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen_q <= 1'b0;
      illegal_cnt_q  <= '0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
      illegal_cnt_q  <= illegal_cnt_d;
    end
  end

  assign illegal_seen = illegal_seen_q;
  assign illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Testbench for alu_ctrl_unit: table-driven decode vectors through an expected-value queue,
// followed by hand-written sequences for the counter, its saturation, the clear and the asynchronous reset.
module tb_alu_ctrl_unit;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [1:0]       alu_op;
  logic [5:0]       func;
  logic             err_clr;
  logic [3:0]       alu_ctrl;
  logic             illegal_func;
  logic             illegal_seen;
  logic [CNT_W-1:0] illegal_cnt;

  alu_ctrl_unit #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_op       (alu_op),
    .func         (func),
    .err_clr      (err_clr),
    .alu_ctrl     (alu_ctrl),
    .illegal_func (illegal_func),
    .illegal_seen (illegal_seen),
    .illegal_cnt  (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] exp_ctrl;
    logic       exp_ill;
  } vec_t;

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
  } exp_t;

  vec_t vecs[16];
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a decode pattern mid-cycle, queue its expectation, then pop and
  // compare once the combinational outputs have settled.
  task automatic apply(input string name, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] e_ctrl, input logic e_ill);
    exp_t e;
    exp_t got;
    alu_op = op;
    func   = fn;
    e.ctrl = e_ctrl;
    e.ill  = e_ill;
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb_q.pop_front();
      chk({name, ".ctrl"}, int'(alu_ctrl), int'(got.ctrl));
      chk({name, ".ill"},  int'(illegal_func), int'(got.ill));
    end
  endtask

  task automatic chk_side(input string name, input logic e_seen, input int e_cnt);
    chk({name, ".seen"}, int'(illegal_seen), int'(e_seen));
    chk({name, ".cnt"},  int'(illegal_cnt), e_cnt);
  endtask

  // Hard stop if the run ever overruns its budget.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'b00, 6'bxxxxxx, 4'b0010, 1'b0};
    vecs[1]  = '{2'b01, 6'b111111, 4'b0110, 1'b0};
    vecs[2]  = '{2'b11, 6'b000000, 4'b0010, 1'b0};
    vecs[3]  = '{2'b10, 6'b100000, 4'b0010, 1'b0};
    vecs[4]  = '{2'b10, 6'b100001, 4'b0010, 1'b0};
    vecs[5]  = '{2'b10, 6'b100010, 4'b0110, 1'b0};
    vecs[6]  = '{2'b10, 6'b100011, 4'b0110, 1'b0};
    vecs[7]  = '{2'b10, 6'b100100, 4'b0000, 1'b0};
    vecs[8]  = '{2'b10, 6'b100101, 4'b0001, 1'b0};
    vecs[9]  = '{2'b10, 6'b100110, 4'b0011, 1'b0};
    vecs[10] = '{2'b10, 6'b100111, 4'b1100, 1'b0};
    vecs[11] = '{2'b10, 6'b101010, 4'b0111, 1'b0};
    vecs[12] = '{2'b10, 6'b101011, 4'b1000, 1'b0};
    vecs[13] = '{2'b10, 6'b111111, 4'b1111, 1'b1};
    vecs[14] = '{2'b10, 6'b000000, 4'b1111, 1'b1};
    vecs[15] = '{2'b10, 6'b101000, 4'b1111, 1'b1};

    rst_n   = 1'b0;
    err_clr = 1'b0;
    alu_op  = 2'b00;
    func    = 6'b000000;
    #3;
    chk_side("reset", 1'b0, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Decode table; err_clr holds the side-band at zero while illegal
    // patterns pass through.
    err_clr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].exp_ctrl, vecs[i].exp_ill);
    end
    @(posedge clk); #1;
    chk_side("table_cleared", 1'b0, 0);

    // An undefined funct outside R-type must not count.
    @(negedge clk);
    err_clr = 1'b0;
    apply("non_rtype", 2'b00, 6'b111111, 4'b0010, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk_side("non_rtype", 1'b0, 0);

    // Three cycles of an illegal funct.
    @(negedge clk);
    apply("ill3", 2'b10, 6'b111111, 4'b1111, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk_side("ill3", 1'b1, 3);

    // Hold it for 300 cycles in total; the counter saturates.
    repeat (297) @(posedge clk);
    #1;
    chk_side("sat", 1'b1, 255);
    repeat (2) @(posedge clk);
    #1;
    chk_side("sat_hold", 1'b1, 255);

    // Clear wins over the illegal funct still present.
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk_side("clr", 1'b0, 0);
    @(negedge clk);
    err_clr = 1'b0;

    // Count twice, then pull reset between clock edges.
    repeat (2) @(posedge clk);
    #1;
    chk_side("pre_rst", 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_side("async_rst", 1'b0, 0);
    apply("rst_track_ill", 2'b10, 6'b111111, 4'b1111, 1'b1);
    apply("rst_track_sub", 2'b01, 6'b000000, 4'b0110, 1'b0);
    @(posedge clk); #1;
    chk_side("rst_held", 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 2'b10, 6'b100101, 4'b0001, 1'b0);
    @(posedge clk); #1;
    chk_side("post_rst", 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
